stream_sequencer: RTL and testbench



---
 rtl/snek_stream_pkg.sv | 35 +++
 rtl/seq_btn_sync.sv | 31 +++
 rtl/stream_sequencer.sv | 132 +++++++++++++
 tb/tb_stream_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snek_stream_pkg.sv
// Shared definitions for the RGB stream sequencer: stream field positions,
// stream width and the sequencer state encoding.
package snek_stream_pkg;

  localparam int STR_W = 26;

  localparam int ACTIVE = 0;
  localparam int VS     = 1;
  localparam int HS     = 2;
  localparam int YC_LO  = 3;
  localparam int YC_HI  = 12;
  localparam int XC_LO  = 13;
  localparam int XC_HI  = 22;
  localparam int R      = 23;
  localparam int G      = 24;
  localparam int B      = 25;

  typedef enum logic [1:0] {
    ST_SPLASH = 2'd0,
    ST_ARMED  = 2'd1,
    ST_GAME   = 2'd2,
    ST_BLANK  = 2'd3
  } state_t;

  // Black pixel with the timing/coordinate fields left untouched.
  function automatic logic [STR_W-1:0] blank_rgb(input logic [STR_W-1:0] word);
    logic [STR_W-1:0] res;
    res    = word;
    res[R] = 1'b0;
    res[G] = 1'b0;
    res[B] = 1'b0;
    return res;
  endfunction

endpackage

// File: rtl/seq_btn_sync.sv
// Start-button conditioning: 2-flop synchronizer followed by a registered
// rising-edge pulse (3 cycles from the raw edge to the pulse).
module seq_btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic meta;
  logic sync;
  logic sync_prev;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour; blocking here would collapse
  // the synchronizer chain into a single stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta      <= 1'b0;
      sync      <= 1'b0;
      sync_prev <= 1'b0;
      pulse     <= 1'b0;
    end else begin
      meta      <= btn;
      sync      <= meta;
      sync_prev <= sync;
      pulse     <= sync & ~sync_prev;
    end
  end

endmodule

// File: rtl/stream_sequencer.sv
// Frame-aligned switch between the splash and game RGB streams, with start
// handshake and game-over return. Define SNEK_SEQ_BLANK_EN to insert black frames.
module stream_sequencer
  import snek_stream_pkg::*;
#(
  parameter int SPLASH_MIN_FRAMES = 60,
  parameter int FRAME_CNT_W       = 8,
  parameter int BLANK_FRAMES      = 2
) (
  input  logic             px_clk,
  input  logic             rst_n,
  input  logic [STR_W-1:0] strRGB_splash_i,
  input  logic [STR_W-1:0] strRGB_game_i,
  input  logic             btn_start_i,
  input  logic             game_over_i,
  output logic [STR_W-1:0] strRGB_o,
  output logic             game_start_o,
  output logic             game_run_o,
  output logic             splash_active_o
);

`ifdef SNEK_SEQ_BLANK_EN
  localparam bit BLANK_ON = (BLANK_FRAMES > 0);
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  localparam logic [FRAME_CNT_W-1:0] MIN_CNT    = FRAME_CNT_W'(SPLASH_MIN_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] BLANK_LAST = FRAME_CNT_W'(BLANK_FRAMES - 1);

  state_t                 state;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic                   over_pend;
  logic                   vs_prev;
  logic                   blank_to_game;
  logic                   start_req;
  logic                   fb;

  seq_btn_sync u_btn_sync (
    .clk   (px_clk),
    .rst_n (rst_n),
    .btn   (btn_start_i),
    .pulse (start_req)
  );

  assign fb = strRGB_splash_i[VS] & ~vs_prev;

  // NOTE: status outputs are registered alongside the state, so each
  // transition branch assigns them together; game_start_o defaults low every
  // cycle so it can only ever be a single-cycle pulse.
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_SPLASH;
      frame_cnt       <= '0;
      over_pend       <= 1'b0;
      vs_prev         <= 1'b0;
      blank_to_game   <= 1'b0;
      strRGB_o        <= '0;
      game_start_o    <= 1'b0;
      game_run_o      <= 1'b0;
      splash_active_o <= 1'b1;
    end else begin
      vs_prev      <= strRGB_splash_i[VS];
      game_start_o <= 1'b0;

      // Source follows the current state: the fb word still comes from the old source.
      case (state)
        ST_GAME:  strRGB_o <= strRGB_game_i;
        ST_BLANK: strRGB_o <= blank_rgb(strRGB_splash_i);
        default:  strRGB_o <= strRGB_splash_i;
      endcase

      case (state)
        ST_SPLASH: begin
          if (fb && frame_cnt != MIN_CNT) frame_cnt <= frame_cnt + 1'b1;
          if (start_req && frame_cnt == MIN_CNT) state <= ST_ARMED;
        end

        ST_ARMED: begin
          if (fb) begin
            frame_cnt       <= '0;
            splash_active_o <= 1'b0;
            if (BLANK_ON) begin
              state         <= ST_BLANK;
              blank_to_game <= 1'b1;
            end else begin
              state        <= ST_GAME;
              game_start_o <= 1'b1;
              game_run_o   <= 1'b1;
            end
          end
        end

        ST_GAME: begin
          over_pend <= over_pend | game_over_i;
          // A game-over arriving on the fb cycle itself takes effect at that fb.
          if (fb && (over_pend || game_over_i)) begin
            over_pend  <= 1'b0;
            frame_cnt  <= '0;
            game_run_o <= 1'b0;
            if (BLANK_ON) begin
              state         <= ST_BLANK;
              blank_to_game <= 1'b0;
            end else begin
              state           <= ST_SPLASH;
              splash_active_o <= 1'b1;
            end
          end
        end

        ST_BLANK: begin
          if (fb) begin
            if (frame_cnt == BLANK_LAST) begin
              frame_cnt <= '0;
              if (blank_to_game) begin
                state        <= ST_GAME;
                game_start_o <= 1'b1;
                game_run_o   <= 1'b1;
              end else begin
                state           <= ST_SPLASH;
                splash_active_o <= 1'b1;
              end
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_sequencer.sv
// Directed bench for stream_sequencer: the stimulus pushes expected outputs
// into a queue, a monitor pops and compares one entry per clock.
module tb_stream_sequencer;
  import snek_stream_pkg::*;

  localparam int MIN_FR   = 4;
  localparam int FL       = 16;
  localparam int TB_BLANK = 2;
`ifdef SNEK_SEQ_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  logic             px_clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [STR_W-1:0] splash_w = '0;
  logic [STR_W-1:0] game_w = '0;
  logic             btn_start = 1'b0;
  logic             game_over = 1'b0;
  logic [STR_W-1:0] str_out;
  logic             game_start;
  logic             game_run;
  logic             splash_active;

  always #5 px_clk = ~px_clk;

  stream_sequencer #(
    .SPLASH_MIN_FRAMES (MIN_FR),
    .FRAME_CNT_W       (8),
    .BLANK_FRAMES      (TB_BLANK)
  ) dut (
    .px_clk          (px_clk),
    .rst_n           (rst_n),
    .strRGB_splash_i (splash_w),
    .strRGB_game_i   (game_w),
    .btn_start_i     (btn_start),
    .game_over_i     (game_over),
    .strRGB_o        (str_out),
    .game_start_o    (game_start),
    .game_run_o      (game_run),
    .splash_active_o (splash_active)
  );

  typedef struct packed {
    logic [STR_W-1:0] str;
    logic             start;
    logic             run;
    logic             splash;
  } exp_t;

  typedef enum int {M_SPLASH, M_GAME, M_BLANK} mode_t;

  exp_t  exp_q[$];
  exp_t  mon_e;
  int    n_checks = 0;
  int    n_errors = 0;

  mode_t mode = M_SPLASH;
  int    blank_left = 0;
  bit    blank_to_game = 1'b0;
  bit    pend_game = 1'b0;
  bit    pend_over = 1'b0;
  int    pix = 0;
  int    frm = 0;
  logic  vs_last = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Splash and game share timing; colour bits differ (game always has B=1).
  function automatic logic [STR_W-1:0] make_word(input int p, input int f, input bit is_game);
    logic       act;
    logic       hs;
    logic       vs;
    logic [2:0] bgr;
    act = (p >= 4 && p < 14);
    hs  = (p == 8);
    vs  = (p < 2);
    bgr = is_game ? {1'b1, p[1], 1'b0} : {1'b0, 1'b1, p[0]};
    return {bgr, 10'(p), 10'(f), hs, vs, act};
  endfunction

  // One pixel: drive both streams, then queue the output expected after the next edge.
  task automatic step();
    exp_t e;
    logic fb;
    @(negedge px_clk);
    splash_w = make_word(pix, frm, 1'b0);
    game_w   = make_word(pix, frm, 1'b1);
    fb       = splash_w[VS] & ~vs_last;
    vs_last  = rst_n ? splash_w[VS] : 1'b0;
    if (rst_n) begin
      case (mode)
        M_GAME:  e.str = game_w;
        M_BLANK: e.str = {3'b000, splash_w[22:0]};
        default: e.str = splash_w;
      endcase
      e.start = 1'b0;
      if (fb) begin
        case (mode)
          M_SPLASH: if (pend_game) begin
            pend_game = 1'b0;
            if (BLANK_ON) begin
              mode = M_BLANK; blank_left = TB_BLANK; blank_to_game = 1'b1;
            end else begin
              mode = M_GAME; e.start = 1'b1;
            end
          end
          M_GAME: if (pend_over) begin
            pend_over = 1'b0;
            if (BLANK_ON) begin
              mode = M_BLANK; blank_left = TB_BLANK; blank_to_game = 1'b0;
            end else begin
              mode = M_SPLASH;
            end
          end
          default: begin
            blank_left--;
            if (blank_left == 0) begin
              if (blank_to_game) begin
                mode = M_GAME; e.start = 1'b1;
              end else begin
                mode = M_SPLASH;
              end
            end
          end
        endcase
      end
      e.run    = (mode == M_GAME);
      e.splash = (mode == M_SPLASH);
      exp_q.push_back(e);
    end
    pix++;
    if (pix == FL) begin
      pix = 0;
      frm++;
    end
  endtask

  task automatic run_to(input int p);
    while (pix != p) step();
  endtask

  task automatic next_frame();
    step();
    run_to(3);
  endtask

  task automatic press();
    btn_start = 1'b1;
    repeat (6) step();
    btn_start = 1'b0;
    repeat (6) step();
  endtask

  task automatic wait_mode(input mode_t target, input string name);
    int guard = 0;
    do begin
      next_frame();
      guard++;
    end while (mode != target && guard < 8);
    check(name, 64'(game_run), 64'(target == M_GAME));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_strRGB_o"}, 64'(str_out), 64'd0);
    check({tag, "_game_start_o"}, 64'(game_start), 64'd0);
    check({tag, "_game_run_o"}, 64'(game_run), 64'd0);
    check({tag, "_splash_active_o"}, 64'(splash_active), 64'd1);
  endtask

  always @(posedge px_clk) begin
    #2;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("strRGB_o", 64'(str_out), 64'(mon_e.str));
      check("game_start_o", 64'(game_start), 64'(mon_e.start));
      check("game_run_o", 64'(game_run), 64'(mon_e.run));
      check("splash_active_o", 64'(splash_active), 64'(mon_e.splash));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (12) step();
    check_reset_vals("por");
    rst_n = 1'b1;

    // Presses at frame counts 2 and 3 are discarded; the one at 4 arms.
    run_to(3);
    next_frame();
    press();
    run_to(3);
    press();
    run_to(3);
    press();
    pend_game = 1'b1;
    wait_mode(M_GAME, "enter_game");
    next_frame();

    // One-cycle game-over mid-frame: takes effect at the next frame start.
    run_to(5);
    game_over = 1'b1;
    step();
    game_over = 1'b0;
    pend_over = 1'b1;
    run_to(7);
    wait_mode(M_SPLASH, "game_over_return");

    // Splash count restarts from zero after returning.
    next_frame();
    next_frame();
    press();
    run_to(3);
    press();
    run_to(3);
    press();
    pend_game = 1'b1;
    wait_mode(M_GAME, "reenter_game");

    // Asynchronous reset in the middle of a game frame.
    next_frame();
    run_to(6);
    @(posedge px_clk);
    #3 rst_n = 1'b0;
    #1 check_reset_vals("async");
    mode = M_SPLASH;
    pend_game = 1'b0;
    pend_over = 1'b0;
    repeat (4) step();
    rst_n = 1'b1;

    run_to(3);
    next_frame();
    next_frame();
    press();
    run_to(3);
    press();
    pend_game = 1'b1;
    wait_mode(M_GAME, "post_reset_game");

    // Game-over asserted on the very cycle VS rises.
    next_frame();
    run_to(0);
    game_over = 1'b1;
    pend_over = 1'b1;
    step();
    game_over = 1'b0;
    wait_mode(M_SPLASH, "simultaneous_over");

    next_frame();
    repeat (3) @(posedge px_clk);
    #3;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
